mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Arbitrates icache line reads and dcache reads/writes onto one memory port.
// Latency: grant one edge after a request is seen in IDLE; response one cycle after memory.
// Backpressure: one outstanding memory transaction; other requesters hold until their ready pulse.
module mem_req_arbiter #(
  parameter int PADDR_WIDTH = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int ASIZE_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // icache side
  input  logic                   ic_rd_req_valid_i,
  input  logic [PADDR_WIDTH-1:0] ic_req_address_i,
  output logic                   ic_req_ready_o,
  output logic                   ic_rsp_valid_o,
  output logic [LINE_WIDTH-1:0]  ic_rsp_data_o,
  // dcache side
  input  logic                   dc_rd_req_valid_i,
  input  logic                   dc_wr_req_valid_i,
  input  logic [PADDR_WIDTH-1:0] dc_req_address_i,
  input  logic [LINE_WIDTH-1:0]  dc_wr_data_i,
  input  logic [ASIZE_WIDTH-1:0] dc_req_access_size_i,
  output logic                   dc_req_ready_o,
  output logic                   dc_rsp_valid_o,
  output logic [LINE_WIDTH-1:0]  dc_rsp_data_o,
  output logic                   dc_wr_done_o,
  // memory side
  output logic                   mem_rd_req_valid_o,
  output logic                   mem_wr_req_valid_o,
  output logic                   mem_req_is_instr_o,
  output logic [PADDR_WIDTH-1:0] mem_req_address_o,
  output logic [LINE_WIDTH-1:0]  mem_wr_data_o,
  output logic [ASIZE_WIDTH-1:0] mem_req_access_size_o,
  input  logic                   mem_data_valid_i,
  input  logic                   mem_data_is_instr_i,
  input  logic [LINE_WIDTH-1:0]  mem_data_i,
  input  logic                   mem_write_done_i,
  // status
  output logic                   error_o
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t state_q, state_d;
  logic   last_dc_q;   // 1: dcache won the previous grant
  logic   ic_pend, dc_pend, dc_is_wr;
  logic   grant_ic, grant_dc;
  logic   rd_done, wr_done;
  logic   err_set;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, arbitration and completion detection
  always_comb begin
    state_d  = state_q;
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    ic_pend  = ic_rd_req_valid_i;
    dc_pend  = dc_rd_req_valid_i | dc_wr_req_valid_i;
    // a simultaneous dcache read+write is served as a write
    dc_is_wr = dc_wr_req_valid_i;
    case (state_q)
      IDLE: begin
        if (ic_pend && dc_pend) begin
          // alternate on a tie: favour whoever did not win last
          if (last_dc_q) grant_ic = 1'b1;
          else           grant_dc = 1'b1;
        end else if (ic_pend) begin
          grant_ic = 1'b1;
        end else if (dc_pend) begin
          grant_dc = 1'b1;
        end
        if (grant_ic) state_d = RD_WAIT;
        if (grant_dc) state_d = dc_is_wr ? WR_WAIT : RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_data_valid_i) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (mem_write_done_i) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Protocol violations; none of these alter the FSM
  always_comb begin
    err_set = 1'b0;
    if (state_q == IDLE && dc_rd_req_valid_i && dc_wr_req_valid_i) err_set = 1'b1;
    if (mem_data_valid_i && state_q != RD_WAIT)                    err_set = 1'b1;
    if (mem_write_done_i && state_q != WR_WAIT)                    err_set = 1'b1;
    if (mem_data_valid_i && state_q == RD_WAIT &&
        mem_data_is_instr_i != mem_req_is_instr_o)                 err_set = 1'b1;
  end

  // Memory request registers: loaded on grant, valid dropped after completion
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_rd_req_valid_o    <= 1'b0;
      mem_wr_req_valid_o    <= 1'b0;
      mem_req_is_instr_o    <= 1'b0;
      mem_req_address_o     <= '0;
      mem_wr_data_o         <= '0;
      mem_req_access_size_o <= '0;
      last_dc_q             <= 1'b0;
    end else begin
      if (grant_ic) begin
        mem_rd_req_valid_o    <= 1'b1;
        mem_req_is_instr_o    <= 1'b1;
        mem_req_address_o     <= ic_req_address_i;
        mem_wr_data_o         <= '0;
        mem_req_access_size_o <= '1;
        last_dc_q             <= 1'b0;
      end
      if (grant_dc) begin
        mem_rd_req_valid_o    <= ~dc_is_wr;
        mem_wr_req_valid_o    <= dc_is_wr;
        mem_req_is_instr_o    <= 1'b0;
        mem_req_address_o     <= dc_req_address_i;
        mem_wr_data_o         <= dc_is_wr ? dc_wr_data_i : '0;
        mem_req_access_size_o <= dc_req_access_size_i;
        last_dc_q             <= 1'b1;
      end
      if (rd_done) mem_rd_req_valid_o <= 1'b0;
      if (wr_done) mem_wr_req_valid_o <= 1'b0;
    end
  end

  // Requester-facing pulses and held response data
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ic_req_ready_o <= 1'b0;
      dc_req_ready_o <= 1'b0;
      ic_rsp_valid_o <= 1'b0;
      dc_rsp_valid_o <= 1'b0;
      dc_wr_done_o   <= 1'b0;
      ic_rsp_data_o  <= '0;
      dc_rsp_data_o  <= '0;
    end else begin
      ic_req_ready_o <= grant_ic;
      dc_req_ready_o <= grant_dc;
      ic_rsp_valid_o <= rd_done & mem_req_is_instr_o;
      dc_rsp_valid_o <= rd_done & ~mem_req_is_instr_o;
      dc_wr_done_o   <= wr_done;
      if (rd_done && mem_req_is_instr_o)  ic_rsp_data_o <= mem_data_i;
      if (rd_done && !mem_req_is_instr_o) dc_rsp_data_o <= mem_data_i;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) error_o <= 1'b0;
    else        error_o <= error_o | err_set;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  localparam int PW = 32;
  localparam int LW = 128;
  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ic_rd_req_valid_i;
  logic [PW-1:0] ic_req_address_i;
  logic          ic_req_ready_o, ic_rsp_valid_o;
  logic [LW-1:0] ic_rsp_data_o;
  logic          dc_rd_req_valid_i, dc_wr_req_valid_i;
  logic [PW-1:0] dc_req_address_i;
  logic [LW-1:0] dc_wr_data_i;
  logic [AW-1:0] dc_req_access_size_i;
  logic          dc_req_ready_o, dc_rsp_valid_o, dc_wr_done_o;
  logic [LW-1:0] dc_rsp_data_o;
  logic          mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o;
  logic [PW-1:0] mem_req_address_o;
  logic [LW-1:0] mem_wr_data_o;
  logic [AW-1:0] mem_req_access_size_o;
  logic          mem_data_valid_i, mem_data_is_instr_i, mem_write_done_i;
  logic [LW-1:0] mem_data_i;
  logic          error_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          is_ic;
    logic [LW-1:0] data;
  } exp_t;
  exp_t sbq[$];
  bit   gq[$];   // expected grant order, 1 = icache

  mem_req_arbiter #(.PADDR_WIDTH(PW), .LINE_WIDTH(LW), .ASIZE_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_rd_req_valid_i(ic_rd_req_valid_i), .ic_req_address_i(ic_req_address_i),
    .ic_req_ready_o(ic_req_ready_o), .ic_rsp_valid_o(ic_rsp_valid_o),
    .ic_rsp_data_o(ic_rsp_data_o),
    .dc_rd_req_valid_i(dc_rd_req_valid_i), .dc_wr_req_valid_i(dc_wr_req_valid_i),
    .dc_req_address_i(dc_req_address_i), .dc_wr_data_i(dc_wr_data_i),
    .dc_req_access_size_i(dc_req_access_size_i), .dc_req_ready_o(dc_req_ready_o),
    .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_data_o(dc_rsp_data_o),
    .dc_wr_done_o(dc_wr_done_o),
    .mem_rd_req_valid_o(mem_rd_req_valid_o), .mem_wr_req_valid_o(mem_wr_req_valid_o),
    .mem_req_is_instr_o(mem_req_is_instr_o), .mem_req_address_o(mem_req_address_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_req_access_size_o(mem_req_access_size_o),
    .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
    .mem_data_i(mem_data_i), .mem_write_done_i(mem_write_done_i),
    .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  // Tick until either ready pulses (bounded); reports which requester won
  task automatic wait_ready(output bit got_ic);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        tick();
        if (ic_req_ready_o || dc_req_ready_o) seen = 1'b1;
      end
    end
    chk("ready_seen", LW'(seen), LW'(1));
    got_ic = ic_req_ready_o;
  endtask

  // Called in the ready cycle; plays memory for a read and checks the response
  task automatic mem_read_rsp(input bit tag, input logic [LW-1:0] data, input int lat);
    exp_t e;
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("rd_valid_held", LW'(mem_rd_req_valid_o), LW'(1));
      chk("ready_pulse", LW'(ic_req_ready_o | dc_req_ready_o), LW'(0));
    end
    mem_data_valid_i    = 1'b1;
    mem_data_is_instr_i = tag;
    mem_data_i          = data;
    tick();
    mem_data_valid_i    = 1'b0;
    mem_data_i          = '0;
    chk("sb_nonempty", LW'(sbq.size() != 0), LW'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("rsp_ic_vld", LW'(ic_rsp_valid_o), LW'(e.is_ic));
      chk("rsp_dc_vld", LW'(dc_rsp_valid_o), LW'(!e.is_ic));
      chk("rsp_data", e.is_ic ? ic_rsp_data_o : dc_rsp_data_o, e.data);
    end
    chk("rd_valid_drop", LW'(mem_rd_req_valid_o), LW'(0));
  endtask

  initial begin
    bit g;
    rst_i = 1'b0;
    ic_rd_req_valid_i = 0; ic_req_address_i = '0;
    dc_rd_req_valid_i = 0; dc_wr_req_valid_i = 0; dc_req_address_i = '0;
    dc_wr_data_i = '0; dc_req_access_size_i = '0;
    mem_data_valid_i = 0; mem_data_is_instr_i = 0; mem_data_i = '0; mem_write_done_i = 0;

    // reset state
    tick(); tick();
    chk("rst_ic_ready", LW'(ic_req_ready_o), LW'(0));
    chk("rst_rd_valid", LW'(mem_rd_req_valid_o), LW'(0));
    chk("rst_wr_valid", LW'(mem_wr_req_valid_o), LW'(0));
    chk("rst_addr", LW'(mem_req_address_o), LW'(0));
    chk("rst_ic_data", ic_rsp_data_o, LW'(0));
    chk("rst_error", LW'(error_o), LW'(0));
    rst_i = 1'b1;
    tick();

    // icache line read, memory answers after 3 cycles
    ic_rd_req_valid_i = 1; ic_req_address_i = 32'h1000;
    sbq.push_back('{is_ic: 1'b1, data: LW'(8'hAB)});
    tick();
    chk("t1_ic_ready", LW'(ic_req_ready_o), LW'(1));
    chk("t1_dc_ready", LW'(dc_req_ready_o), LW'(0));
    ic_rd_req_valid_i = 0;
    chk("t1_rd_valid", LW'(mem_rd_req_valid_o), LW'(1));
    chk("t1_is_instr", LW'(mem_req_is_instr_o), LW'(1));
    chk("t1_addr", LW'(mem_req_address_o), LW'(32'h1000));
    chk("t1_size", LW'(mem_req_access_size_o), LW'(2'b11));
    mem_read_rsp(1'b1, LW'(8'hAB), 3);
    tick();
    chk("t1_rsp_pulse", LW'(ic_rsp_valid_o), LW'(0));
    chk("t1_data_held", ic_rsp_data_o, LW'(8'hAB));
    chk("t1_dc_data", dc_rsp_data_o, LW'(0));
    chk("t1_dc_vld", LW'(dc_rsp_valid_o | dc_wr_done_o), LW'(0));
    chk("t1_error", LW'(error_o), LW'(0));

    // dcache word store, with an icache request dropped while busy
    dc_wr_req_valid_i = 1; dc_req_address_i = 32'h1FF8;
    dc_wr_data_i = LW'(32'hDEADBEEF); dc_req_access_size_i = 2'b10;
    wait_ready(g);
    chk("t2_grant_dc", LW'(g), LW'(0));
    dc_wr_req_valid_i = 0;
    chk("t2_wr_valid", LW'(mem_wr_req_valid_o), LW'(1));
    chk("t2_rd_valid", LW'(mem_rd_req_valid_o), LW'(0));
    chk("t2_addr", LW'(mem_req_address_o), LW'(32'h1FF8));
    chk("t2_wdata", mem_wr_data_o, LW'(32'hDEADBEEF));
    chk("t2_size", LW'(mem_req_access_size_o), LW'(2'b10));
    ic_rd_req_valid_i = 1;
    tick();
    ic_rd_req_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wr_held", LW'(mem_wr_req_valid_o), LW'(1));
      chk("t2_no_done", LW'(dc_wr_done_o), LW'(0));
      tick();
    end
    mem_write_done_i = 1;
    tick();
    mem_write_done_i = 0;
    chk("t2_done", LW'(dc_wr_done_o), LW'(1));
    chk("t2_wr_drop", LW'(mem_wr_req_valid_o), LW'(0));
    tick();
    chk("t2_done_pulse", LW'(dc_wr_done_o), LW'(0));
    tick(); tick();
    chk("t2_dropped_req", LW'(ic_req_ready_o | mem_rd_req_valid_o), LW'(0));
    chk("t2_error", LW'(error_o), LW'(0));

    // simultaneous requests after reset alternate dcache, icache, dcache
    do_reset();
    gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
    ic_rd_req_valid_i = 1; ic_req_address_i = 32'h2000;
    dc_rd_req_valid_i = 1; dc_req_address_i = 32'h3000; dc_req_access_size_i = 2'b01;
    wait_ready(g);
    chk("arb_0", LW'(g), LW'(gq.pop_front()));
    dc_rd_req_valid_i = 0;
    sbq.push_back('{is_ic: 1'b0, data: LW'(8'h11)});
    mem_read_rsp(1'b0, LW'(8'h11), 2);
    dc_rd_req_valid_i = 1;
    wait_ready(g);
    chk("arb_1", LW'(g), LW'(gq.pop_front()));
    chk("arb_1_addr", LW'(mem_req_address_o), LW'(32'h2000));
    ic_rd_req_valid_i = 0;
    sbq.push_back('{is_ic: 1'b1, data: LW'(8'h22)});
    mem_read_rsp(1'b1, LW'(8'h22), 1);
    ic_rd_req_valid_i = 1;
    wait_ready(g);
    chk("arb_2", LW'(g), LW'(gq.pop_front()));
    dc_rd_req_valid_i = 0;
    sbq.push_back('{is_ic: 1'b0, data: LW'(8'h33)});
    mem_read_rsp(1'b0, LW'(8'h33), 2);
    ic_rd_req_valid_i = 0;
    tick();
    chk("arb_idle", LW'(ic_req_ready_o | dc_req_ready_o), LW'(0));
    chk("arb_error", LW'(error_o), LW'(0));

    // stray memory response in IDLE is sticky until reset
    mem_data_valid_i = 1;
    tick();
    mem_data_valid_i = 0;
    chk("stray_err", LW'(error_o), LW'(1));
    tick(); tick();
    chk("stray_sticky", LW'(error_o), LW'(1));
    do_reset();
    chk("err_cleared", LW'(error_o), LW'(0));

    // dcache read answered with icache tag: flagged, data still delivered
    dc_rd_req_valid_i = 1; dc_req_address_i = 32'h4000;
    wait_ready(g);
    dc_rd_req_valid_i = 0;
    sbq.push_back('{is_ic: 1'b0, data: LW'(16'h5A5A)});
    mem_read_rsp(1'b1, LW'(16'h5A5A), 1);
    chk("tag_err", LW'(error_o), LW'(1));
    do_reset();

    // dcache read and write together: served as a write, flagged
    dc_rd_req_valid_i = 1; dc_wr_req_valid_i = 1; dc_wr_data_i = LW'(8'h77);
    wait_ready(g);
    dc_rd_req_valid_i = 0; dc_wr_req_valid_i = 0;
    chk("rw_wr_valid", LW'(mem_wr_req_valid_o), LW'(1));
    chk("rw_rd_valid", LW'(mem_rd_req_valid_o), LW'(0));
    chk("rw_err", LW'(error_o), LW'(1));
    mem_write_done_i = 1;
    tick();
    mem_write_done_i = 0;
    chk("rw_done", LW'(dc_wr_done_o), LW'(1));
    do_reset();

    // reset during RD_WAIT abandons the read; late response is an error
    ic_rd_req_valid_i = 1; ic_req_address_i = 32'h5000;
    wait_ready(g);
    ic_rd_req_valid_i = 0;
    tick();
    rst_i = 1'b0;
    tick();
    chk("mid_rst_rd_valid", LW'(mem_rd_req_valid_o), LW'(0));
    chk("mid_rst_addr", LW'(mem_req_address_o), LW'(0));
    chk("mid_rst_instr", LW'(mem_req_is_instr_o), LW'(0));
    chk("mid_rst_rsp", LW'(ic_rsp_valid_o | dc_rsp_valid_o), LW'(0));
    rst_i = 1'b1;
    tick();
    mem_data_valid_i = 1; mem_data_is_instr_i = 1; mem_data_i = LW'(8'hCD);
    tick();
    mem_data_valid_i = 0;
    chk("late_err", LW'(error_o), LW'(1));
    chk("late_no_rsp", LW'(ic_rsp_valid_o), LW'(0));
    tick();
    chk("late_no_rsp2", LW'(ic_rsp_valid_o), LW'(0));
    chk("late_data", ic_rsp_data_o, LW'(0));
    chk("sb_drained", LW'(sbq.size()), LW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
